huffman_canon_decoder: RTL and testbench

Parametrised, table-programmable canonical Huffman decoder. It consumes a serial bitstream one bit per accepted cycle and emits one decoded symbol per completed codeword. It replaces fixed-tree serial decoders in the decompression path: the code is defined at run time by a per-length count table and a symbol table, and both sides have valid/ready flow control.

---
 rtl/huff_pkg.sv | 43 ++++
 rtl/huff_table.sv | 51 +++++
 rtl/huffman_canon_decoder.sv | 159 +++++++++++++++
 tb/tb_huffman_canon_decoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared encodings, FSM states and width helpers for the canonical Huffman decoder.
package huff_pkg;

  typedef enum logic {
    CFG_COUNT  = 1'b0,
    CFG_SYMBOL = 1'b1
  } cfg_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Count entries must hold 0..NSYM inclusive.
  function automatic int unsigned cfg_cw(input int unsigned nsym);
    return clog2(nsym + 1);
  endfunction

  function automatic int unsigned cfg_aw(input int unsigned max_len, input int unsigned nsym);
    return clog2(max2(max_len, nsym));
  endfunction

  function automatic int unsigned cfg_dw(input int unsigned sym_w, input int unsigned nsym);
    return max2(sym_w, cfg_cw(nsym));
  endfunction

endpackage

// File: rtl/huff_table.sv
// Run-time code tables: per-length codeword counts and the canonical symbol table.
module huff_table
  import huff_pkg::*;
#(
  parameter int unsigned SYM_W   = 3,
  parameter int unsigned MAX_LEN = 4,
  parameter int unsigned NSYM    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   we_i,
  input  logic                                   sel_i,
  input  logic [cfg_aw(MAX_LEN, NSYM)-1:0]       waddr_i,
  input  logic [cfg_dw(SYM_W, NSYM)-1:0]         wdata_i,
  input  logic [clog2(MAX_LEN + 1)-1:0]          cnt_addr_i,
  output logic [cfg_cw(NSYM)-1:0]                cnt_c,
  input  logic [cfg_aw(MAX_LEN, NSYM)-1:0]       sym_addr_i,
  output logic [SYM_W-1:0]                       sym_c
);

  localparam int unsigned CW = cfg_cw(NSYM);

  logic [CW-1:0]    count_q  [MAX_LEN];
  logic [SYM_W-1:0] symtab_q [NSYM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) count_q[i] <= '0;
      for (int unsigned i = 0; i < NSYM; i++) symtab_q[i] <= '0;
    end else if (we_i) begin
      for (int unsigned i = 0; i < MAX_LEN; i++)
        if (sel_i == CFG_COUNT && 32'(waddr_i) == i) count_q[i] <= wdata_i[CW-1:0];
      for (int unsigned i = 0; i < NSYM; i++)
        if (sel_i == CFG_SYMBOL && 32'(waddr_i) == i) symtab_q[i] <= wdata_i[SYM_W-1:0];
    end
  end

  // Mux-style reads keep out-of-range addresses harmless (they read 0).
  always_comb begin
    cnt_c = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      if (32'(cnt_addr_i) == i) cnt_c = count_q[i];
  end

  always_comb begin
    sym_c = '0;
    for (int unsigned i = 0; i < NSYM; i++)
      if (32'(sym_addr_i) == i) sym_c = symtab_q[i];
  end

endmodule

// File: rtl/huffman_canon_decoder.sv
// Serial canonical Huffman decoder, one bit per accepted cycle, table-programmable.
// Define HUFF_DEC_ERR_EN to enable the invalid-codeword err pulse.
module huffman_canon_decoder
  import huff_pkg::*;
#(
  parameter int unsigned SYM_W   = 3,
  parameter int unsigned MAX_LEN = 4,
  parameter int unsigned NSYM    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             bit_in,
  input  logic                             bit_valid,
  output logic                             bit_ready,
  output logic [SYM_W-1:0]                 sym,
  output logic                             sym_valid,
  input  logic                             sym_ready,
  output logic                             err,
  input  logic                             cfg_we,
  input  logic                             cfg_sel,
  input  logic [cfg_aw(MAX_LEN, NSYM)-1:0] cfg_addr,
  input  logic [cfg_dw(SYM_W, NSYM)-1:0]   cfg_data
);

  localparam int unsigned AW   = cfg_aw(MAX_LEN, NSYM);
  localparam int unsigned CW   = cfg_cw(NSYM);
  localparam int unsigned LW   = MAX_LEN + 1;
  localparam int unsigned LENW = clog2(MAX_LEN + 1);
  localparam int unsigned XW   = max2(LW, CW);
  localparam int unsigned SW   = LW + 1;

  state_e            state_q, state_d;
  logic [LW-1:0]     code_q, code_d;
  logic [LW-1:0]     first_q, first_d;
  logic [LW-1:0]     index_q, index_d;
  logic [LENW-1:0]   len_q, len_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic              sym_valid_q, sym_valid_d;

  logic              bit_acc;
  logic [LW-1:0]     c, diff, cnt_lw, first_sum;
  logic [SW-1:0]     sum;
  logic [AW-1:0]     sym_idx;
  logic [CW-1:0]     cnt_rd;
  logic [SYM_W-1:0]  sym_rd;
  logic              hit, last;

  huff_table #(
    .SYM_W  (SYM_W),
    .MAX_LEN(MAX_LEN),
    .NSYM   (NSYM)
  ) u_table (
    .clk       (clk),
    .rst_n     (reset),
    .we_i      (cfg_we),
    .sel_i     (cfg_sel),
    .waddr_i   (cfg_addr),
    .wdata_i   (cfg_data),
    .cnt_addr_i(len_q),
    .cnt_c     (cnt_rd),
    .sym_addr_i(sym_idx),
    .sym_c     (sym_rd)
  );

  assign bit_ready = !(sym_valid_q && !sym_ready);
  assign bit_acc   = bit_valid && bit_ready;

  // Canonical step: compare offset within this length against count[len+1].
  assign c         = (len_q != '0) ? LW'({code_q, bit_in}) : LW'(bit_in);
  assign diff      = c - first_q;
  assign hit       = XW'(diff) < XW'(cnt_rd);
  assign last      = (len_q == LENW'(MAX_LEN - 1));
  assign cnt_lw    = LW'(cnt_rd);
  assign first_sum = first_q + cnt_lw;
  assign sum       = SW'(index_q) + SW'(diff);
  assign sym_idx   = AW'(32'(sum) % NSYM);

`ifdef HUFF_DEC_ERR_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    first_d     = first_q;
    index_d     = index_q;
    len_d       = len_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q && !sym_ready;
`ifdef HUFF_DEC_ERR_EN
    err_d       = 1'b0;
`endif
    if (cfg_we && (state_q == ST_ACC || bit_acc)) begin
      // Table change invalidates any partial codeword; the bit is dropped.
      state_d = ST_IDLE;
      code_d  = '0;
      first_d = '0;
      index_d = '0;
      len_d   = '0;
    end else if (bit_acc) begin
      if (hit || last) begin
        state_d = ST_IDLE;
        code_d  = '0;
        first_d = '0;
        index_d = '0;
        len_d   = '0;
        if (hit) begin
          sym_d       = sym_rd;
          sym_valid_d = 1'b1;
        end
`ifdef HUFF_DEC_ERR_EN
        else begin
          err_d = 1'b1;
        end
`endif
      end else begin
        state_d = ST_ACC;
        code_d  = c;
        first_d = LW'({first_sum, 1'b0});
        index_d = index_q + cnt_lw;
        len_d   = len_q + LENW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      len_q       <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      first_q     <= first_d;
      index_q     <= index_d;
      len_q       <= len_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
    end
  end

`ifdef HUFF_DEC_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign sym       = sym_q;
  assign sym_valid = sym_valid_q;

endmodule

// File: tb/tb_huffman_canon_decoder.sv
// Directed bench for huffman_canon_decoder; expected symbols derived by hand from the canonical tables.
module tb_huffman_canon_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in, bit_valid, bit_ready;
  logic [2:0] sym;
  logic       sym_valid, sym_ready, err;
  logic       cfg_we, cfg_sel;
  logic [2:0] cfg_addr;
  logic [3:0] cfg_data;

  int n_chk = 0;
  int n_bad = 0;

`ifdef HUFF_DEC_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  huffman_canon_decoder #(.SYM_W(3), .MAX_LEN(4), .NSYM(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .sym      (sym),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .err      (err),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic sel, input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = 3'(addr);
    cfg_data = 4'(data);
    tick();
    cfg_we   = 1'b0;
  endtask

  // Counts {1,0,3,2}: 0->1, 100/101/110->2/3/4, 1110/1111->5/6.
  task automatic load_tab1();
    int cnt[4];
    cnt = '{1, 0, 3, 2};
    for (int i = 0; i < 4; i++) prog(1'b0, i, cnt[i]);
    for (int i = 0; i < 6; i++) prog(1'b1, i, i + 1);
  endtask

  task automatic send(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_cw(input string tag, input int len, input logic [3:0] bits,
                         input logic exp_hit, input logic [2:0] exp_sym, input logic exp_err);
    for (int i = len - 1; i >= 0; i--) begin
      send(bits[i]);
      if (i > 0) begin
        check({tag, "_mid_v"}, 32'(sym_valid), 32'(0));
        check({tag, "_mid_err"}, 32'(err), 32'(0));
      end
    end
    check({tag, "_v"}, 32'(sym_valid), 32'(exp_hit));
    if (exp_hit) check({tag, "_sym"}, 32'(sym), 32'(exp_sym));
    check({tag, "_err"}, 32'(err), 32'(exp_err && !exp_hit));
  endtask

  initial begin
    int         cw_len[6];
    logic [3:0] cw_bits[6];
    cw_len  = '{1, 3, 3, 3, 4, 4};
    cw_bits = '{4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b1110, 4'b1111};

    reset = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (2) tick();
    check("rst_sym", 32'(sym), 32'(0));
    check("rst_v", 32'(sym_valid), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_rdy", 32'(bit_ready), 32'(1));
    reset = 1'b1;
    tick();

    // Cleared table: every 4-bit word is invalid.
    send_cw("clr0000", 4, 4'b0000, 1'b0, 3'd0, ERR_EXP);

    // All six codewords back to back.
    load_tab1();
    for (int k = 0; k < 6; k++)
      send_cw($sformatf("cw%0d", k), cw_len[k], cw_bits[k], 1'b1, 3'(k + 1), 1'b0);

    // 1-bit code sustains one symbol per cycle.
    for (int k = 0; k < 8; k++) begin
      send(1'b0);
      check("stream_v", 32'(sym_valid), 32'(1));
      check("stream_sym", 32'(sym), 32'(1));
      check("stream_rdy", 32'(bit_ready), 32'(1));
    end

    // Backpressure: the first bit of 1110 is held until sym_ready returns.
    send(1'b0);
    sym_ready = 1'b0;
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    #1;
    check("bp_rdy0", 32'(bit_ready), 32'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_v", 32'(sym_valid), 32'(1));
      check("bp_hold_sym", 32'(sym), 32'(1));
      check("bp_hold_rdy", 32'(bit_ready), 32'(0));
    end
    sym_ready = 1'b1;
    tick();
    bit_valid = 1'b0;
    check("bp_resume_v", 32'(sym_valid), 32'(0));
    send_cw("bp_rest", 3, 4'b0110, 1'b1, 3'd5, 1'b0);

    // Single 4-bit code 0000 -> 7; 1111 is invalid.
    for (int i = 0; i < 4; i++) prog(1'b0, i, (i == 3) ? 1 : 0);
    prog(1'b1, 0, 7);
    send_cw("e1111", 4, 4'b1111, 1'b0, 3'd0, ERR_EXP);
    send_cw("e0000", 4, 4'b0000, 1'b1, 3'd7, 1'b0);

    // Asynchronous reset mid-codeword clears outputs and tables.
    load_tab1();
    send(1'b1);
    send(1'b1);
    check("pre_rst_sym", 32'(sym), 32'(7));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_sym", 32'(sym), 32'(0));
    check("mid_rst_v", 32'(sym_valid), 32'(0));
    check("mid_rst_err", 32'(err), 32'(0));
    check("mid_rst_rdy", 32'(bit_ready), 32'(1));
    repeat (2) tick();
    reset = 1'b1;
    tick();
    load_tab1();
    send_cw("post_rst0", 1, 4'b0000, 1'b1, 3'd1, 1'b0);

    // Config write while accumulating drops the partial 11.
    send(1'b1);
    send(1'b1);
    prog(1'b0, 0, 1);
    check("abort_err", 32'(err), 32'(0));
    send_cw("abort0", 1, 4'b0000, 1'b1, 3'd1, 1'b0);

    // Config write coincident with an accepted bit discards that bit.
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_data = 4'd1;
    bit_in = 1'b1; bit_valid = 1'b1;
    tick();
    cfg_we = 1'b0; bit_valid = 1'b0;
    check("coin_v", 32'(sym_valid), 32'(0));
    check("coin_err", 32'(err), 32'(0));
    send_cw("coin0", 1, 4'b0000, 1'b1, 3'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
